// File: rtl/bpsk_pkg.sv
// Shared types and helpers for the BPSK modulator datapath.
package bpsk_pkg;

  localparam int unsigned DEF_SAMPLE_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  // Offset-binary zero for a w-bit DAC word (w <= 32).
  function automatic logic [31:0] midscale(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  // Two's-complement negation of a w-bit value; the most-negative code
  // saturates to the most-positive code instead of wrapping onto itself.
  function automatic logic [31:0] sat_negate(input logic [31:0] x, input int unsigned w);
    logic [31:0] mask;
    logic [31:0] xm;
    logic [31:0] most_neg;
    mask     = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    xm       = x & mask;
    most_neg = 32'd1 << (w - 1);
    if (xm == most_neg) begin
      return most_neg - 32'd1;
    end
    return (32'd0 - xm) & mask;
  endfunction

endpackage

// File: rtl/bpsk_modulator_if.sv
// DAC word handshake: data/data-valid from the modulator, acknowledge from the DAC.
interface bpsk_modulator_if #(
  parameter int unsigned SAMPLE_W = bpsk_pkg::DEF_SAMPLE_W
);
  logic [SAMPLE_W-1:0] dac_data;
  logic                dac_dav;
  logic                dac_ack;

  modport master (output dac_data, output dac_dav, input dac_ack);
  modport slave  (input dac_data, input dac_dav, output dac_ack);
endinterface

// File: rtl/bpsk_dac_if.sv
// Output holding register for the DAC: dac_dav/dac_ack handshake and a
// sticky overrun flag for samples that arrive while a word is still pending.
module bpsk_dac_if
  import bpsk_pkg::*;
#(
  parameter int unsigned SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_load,
  input  logic [SAMPLE_W-1:0] sample_word,
  bpsk_modulator_if.master    dac,
  output logic                overrun
);

  // Load new words, retire acknowledged ones, flag samples dropped on a busy DAC.
  always_ff @(posedge clk) begin
    if (rst) begin
      dac.dac_data <= SAMPLE_W'(midscale(SAMPLE_W));
      dac.dac_dav  <= 1'b0;
      overrun      <= 1'b0;
    end else if (sample_load) begin
      if (dac.dac_dav && !dac.dac_ack) begin
        overrun <= 1'b1;
      end else begin
        // An ack in the same cycle frees the register, so the new word goes straight in.
        dac.dac_data <= sample_word;
        dac.dac_dav  <= 1'b1;
      end
    end else if (dac.dac_dav && dac.dac_ack) begin
      dac.dac_dav <= 1'b0;
    end
  end

endmodule

// File: rtl/bpsk_modulator.sv
// BPSK modulator: holds each data bit for SAMPLES_PER_SYM sine samples and
// negates or passes each sample, then hands offset-binary words to the DAC.
// Optional build macro BPSK_DIFF_EN selects differential encoding (a phase
// register toggled by each loaded 1 bit selects negation instead of the bit).
module bpsk_modulator
  import bpsk_pkg::*;
#(
  parameter int unsigned SAMPLE_W        = DEF_SAMPLE_W,
  parameter int unsigned SAMPLES_PER_SYM = 32,
  parameter int unsigned CNT_W           = $clog2(SAMPLES_PER_SYM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mod_en,
  input  logic [SAMPLE_W-1:0] sine_sample,
  input  logic                sine_valid,
  input  logic                bit_in,
  input  logic                bit_valid,
  output logic                bit_ready,
  output logic                data_rdy,
  output logic                sym_strobe,
  bpsk_modulator_if.master    dac,
  output logic                overrun
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES_PER_SYM - 1);

  state_t              state;
  state_t              state_nx;
  logic [CNT_W-1:0]    cnt;
  logic                cur_bit;
  logic                sample_load;
  logic                last_sample;
  logic                load_bit;
  logic                neg;
  logic [SAMPLE_W-1:0] signed_res;
  logic [SAMPLE_W-1:0] dac_word;

  assign sample_load = (state == RUN) && sine_valid;
  assign last_sample = sample_load && (cnt == LAST_CNT);
  assign load_bit    = ((state == LOAD) && bit_valid) ||
                       (last_sample && mod_en && bit_valid);

  // Next-state and handshake outputs; end-of-symbol outputs are combinational.
  always_comb begin
    state_nx   = state;
    bit_ready  = 1'b0;
    data_rdy   = 1'b0;
    sym_strobe = 1'b0;
    unique case (state)
      IDLE: begin
        if (mod_en) state_nx = LOAD;
      end
      LOAD: begin
        bit_ready = 1'b1;
        if (bit_valid)   state_nx = RUN;
        else if (!mod_en) state_nx = IDLE;
      end
      RUN: begin
        data_rdy = 1'b1;
        if (last_sample) begin
          sym_strobe = 1'b1;
          bit_ready  = 1'b1;
          if (mod_en && bit_valid) state_nx = RUN;
          else if (mod_en)         state_nx = LOAD;
          else                     state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, symbol sample counter and current symbol bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cur_bit <= 1'b0;
    end else begin
      state <= state_nx;
      if (load_bit) begin
        cur_bit <= bit_in;
        cnt     <= '0;
      end else if (sample_load) begin
        // Wrap explicitly so non-power-of-two symbol lengths also restart at 0.
        cnt <= (cnt == LAST_CNT) ? '0 : cnt + CNT_W'(1);
      end
    end
  end

`ifdef BPSK_DIFF_EN
  logic phase;

  // Differential phase: a loaded 1 flips the carrier phase, a 0 keeps it.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= 1'b0;
    end else if (load_bit) begin
      phase <= phase ^ bit_in;
    end
  end

  assign neg = phase;
`else
  assign neg = cur_bit;
`endif

  // Apply symbol sign, then convert to offset binary by inverting the MSB.
  always_comb begin
    signed_res = neg ? SAMPLE_W'(sat_negate(32'(sine_sample), SAMPLE_W)) : sine_sample;
    dac_word   = {~signed_res[SAMPLE_W-1], signed_res[SAMPLE_W-2:0]};
  end

  bpsk_dac_if #(
    .SAMPLE_W (SAMPLE_W)
  ) u_dac_if (
    .clk         (clk),
    .rst         (rst),
    .sample_load (sample_load),
    .sample_word (dac_word),
    .dac         (dac),
    .overrun     (overrun)
  );

endmodule

// File: doc/bpsk_modulator.md
# bpsk_modulator

Datapath stage between the sine generator and the DAC interface that applies BPSK phase modulation. Each data bit is held for a fixed number of sine samples, and every sample is negated or passed through according to the current symbol. The result goes to the DAC in offset binary using a data-valid/acknowledge handshake. `data_rdy` is the feedback to the BPSK controller, which gates the sine clock and `mod_en` from it.

## Interface
Parameters:
- `SAMPLE_W`, default 12: sine/DAC sample width.
- `SAMPLES_PER_SYM`, default 32: sine samples per bit, ≥2.
- `CNT_W`, default $clog2(SAMPLES_PER_SYM): width of the symbol sample counter.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `mod_en`  in  1  modulation enable from the controller.
- `sine_sample`  in  SAMPLE_W  signed two's-complement sine sample.
- `sine_valid`  in  1  one-cycle strobe, `sine_sample` valid.
- `bit_in`  in  1  next data bit.
- `bit_valid`  in  1  `bit_in` valid.
- `bit_ready`  out  1  bit accepted when `bit_valid && bit_ready`.
- `data_rdy`  out  1  a symbol is loaded and running.
- `sym_strobe`  out  1  one-cycle pulse on the last sample of each symbol.
- `dac_data`  out  SAMPLE_W  offset-binary DAC word.
- `dac_dav`  out  1  `dac_data` valid.
- `dac_ack`  in  1  DAC has taken the word.
- `overrun`  out  1  sticky; a sample was dropped while `dac_dav` was pending.

## Operation
States: IDLE, LOAD, RUN.
- **IDLE**
  - `bit_ready` = 0, `data_rdy` = 0.
  - Go to LOAD when `mod_en` = 1.
- **LOAD**
  - `bit_ready` = 1.
  - On transfer: latch the bit into `cur_bit`, clear the counter, go to RUN.
  - If `mod_en` = 0, go to IDLE.
- **RUN**
  - `data_rdy` = 1.
  - On each `sine_valid`: produce an output sample and increment the counter.
  - On `sine_valid` with counter == SAMPLES_PER_SYM-1:
    - pulse `sym_strobe` and assert `bit_ready` combinationally that cycle;
    - if `mod_en` = 1 and `bit_valid` = 1, load the next bit, clear the counter and stay in RUN (back-to-back symbols, no gap);
    - if `mod_en` = 1 and no bit is offered, go to LOAD;
    - if `mod_en` = 0, go to IDLE.
  - Dropping `mod_en` mid-symbol finishes the current symbol first.

Sample mapping:
- Symbol sign: `cur_bit` = 0 gives +sine, 1 gives −sine.
- Negation is two's complement, except the most-negative input saturates to the most-positive value (0x800 → 0x7FF for W=12).
- Output word = signed result with its MSB inverted (offset binary).

DAC handshake:
- A new output sample loads `dac_data` and sets `dac_dav`.
- `dac_dav` clears on the cycle after `dac_ack` is sampled high.
- `dac_data` is stable while `dac_dav` = 1.
- `dac_ack` while `dac_dav` = 0 is ignored.

Boundary rules:
- **Overrun:** a `sine_valid` while `dac_dav` = 1 and `dac_ack` = 0 drops the sample, sets `overrun`, and still advances the counter so symbol timing is preserved.
- **Simultaneous ack and new sample:** `sine_valid` and `dac_ack` in the same cycle loads the new sample and keeps `dac_dav` = 1; this is not an overrun.
- **`rst` mid-operation:** aborts the symbol, discards the pending DAC word and returns to IDLE.

## Timing
- Reset values:
  - state IDLE;
  - `bit_ready`, `data_rdy`, `sym_strobe`, `dac_dav`, `overrun` all 0;
  - `dac_data` = midscale 2^(SAMPLE_W-1);
  - `cur_bit` = 0, counter = 0.
- Latency: `sine_valid` at cycle n gives `dac_data`/`dac_dav` registered at n+1.
- `data_rdy` rises the cycle after the LOAD transfer.
- `sym_strobe` and the end-of-symbol `bit_ready` are combinational in the cycle of the last `sine_valid`.
- Sustained rate: one sample per cycle, provided `dac_ack` returns the cycle after `dac_dav`.

## Configuration
- `BPSK_DIFF_EN` defined: differential encoding.
  - A phase register toggles on loading a 1 bit and holds on a 0 bit; the phase, not the bit, selects negation.
  - The phase register resets to 0 (+sine).
- `BPSK_DIFF_EN` undefined: absolute mapping as above; no phase register.

## Structure
- Package `bpsk_pkg`:
  - state enum (IDLE, LOAD, RUN);
  - default `SAMPLE_W`;
  - function `midscale(W)`;
  - function `sat_negate`.
- Sub-module `bpsk_dac_if`: output holding register, `dac_dav`/`dac_ack` handshake and `overrun` flag.
- The top holds the FSM, counter and sign logic.

## Test plan
All scenarios use SAMPLES_PER_SYM=4, W=12.
- **Reset:** assert `rst` mid-RUN → next cycle state IDLE, `dac_data` = 0x800, `dac_dav` = 0, `data_rdy` = 0.
- **Back-to-back symbols:** bits 0 then 1 back-to-back, sine 0x100 every cycle, `dac_ack` prompt → four words 0x900, then four words 0x700, no gap; `sym_strobe` pulses every 4th sample.
- **Saturation:** bit 1, sample 0x800 → `dac_data` = 0xFFF (saturated 0x7FF with MSB inverted).
- **Overrun:** hold `dac_ack` = 0 and send 2 samples → second sample dropped, `overrun` = 1 until `rst`, symbol still ends after 4 `sine_valid`.
- **Underflow and disable:** no `bit_valid` at end of symbol → LOAD, `data_rdy` = 0; `mod_en` dropped mid-symbol → remaining samples still output, then IDLE.
- **Differential mode:** with `BPSK_DIFF_EN`, bits 1,1,0 → phases −,+,+ on sample 0x100 (0x700, 0x900, 0x900).
